// File: rtl/unix_pkg.sv
// unix_pkg: shared definitions for the Unix timestamp load path.
//   state_t     - sequencer FSM states
//   UNIX_WIDTH  - width of a Unix timestamp in bits
//   EPOCH_2020  - seconds from 1970-01-01 to 2020-01-01; also used by
//                 the display/normalisation logic
package unix_pkg;

  localparam int unsigned UNIX_WIDTH = 32;

  // 18262 days * 86400 s/day = 1577836800, fits in 31 bits.
  localparam logic [31:0] EPOCH_2020 = 32'(18262 * 86400);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  // Seconds elapsed since 2020-01-01 for a timestamp at or after that date.
  function automatic logic [31:0] unix_since_2020(input logic [31:0] i_ts);
    return i_ts - EPOCH_2020;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with last-grant state.
//   clk, reset_n     - system clock, asynchronous active-low reset
//   i_en             - grants may only be issued while high
//   i_req0, i_req1   - requests
//   o_gnt0, o_gnt1   - combinational one-hot grants
//   o_last           - source of the most recent grant (1 after reset, so
//                      source 0 wins the first tie)
module rr_arbiter2 (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1,
  output logic o_last
);

  logic r_last;

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_en) begin
      if (i_req0 && i_req1) begin
        // Tie: the source that did not win last time goes next.
        o_gnt0 = r_last;
        o_gnt1 = ~r_last;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (o_gnt0) begin
      r_last <= 1'b0;
    end else if (o_gnt1) begin
      r_last <= 1'b1;
    end
  end

  assign o_last = r_last;

endmodule

// File: rtl/unix_load_sequencer.sv
// unix_load_sequencer: loads a WIDTH-bit Unix timestamp into a downstream
// serial-in register. Two request sources are arbitrated round-robin; the
// accepted word is cleared downstream, then shifted out LSB-first on a
// serial clock with half-period CLK_DIV system clocks.
//   clk, reset_n        - system clock, asynchronous active-low reset
//   req0/data0/ack0     - source 0 (host time set); ack is a same-cycle pulse
//   req1/data1/ack1     - source 1 (periodic resync)
//   unix_clr            - clear to the downstream register
//   unix_sclk/unix_data - serial clock (sampled on rising edge) and data
//   busy                - FSM not idle
//   done                - one-cycle pulse after the last bit
//   unix_valid          - downstream register holds a complete word
//   grant_src           - source of the current/last accepted load
module unix_load_sequencer
  import unix_pkg::*;
#(
  parameter int unsigned WIDTH   = UNIX_WIDTH,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             unix_clr,
  output logic             unix_sclk,
  output logic             unix_data,
  output logic             busy,
  output logic             done,
  output logic             unix_valid,
  output logic             grant_src
);

  localparam int unsigned DIVW = $clog2(CLK_DIV + 1);
  localparam int unsigned BITW = $clog2(WIDTH + 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [DIVW-1:0]  r_div;
  logic [DIVW-1:0]  w_div_nxt;
  logic [BITW-1:0]  r_bit;
  logic [BITW-1:0]  w_bit_nxt;
  logic             w_div_last;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_last;
  logic             w_data_nxt;
  logic             w_valid_nxt;

  logic r_clr;
  logic r_sclk;
  logic r_data;
  logic r_busy;
  logic r_done;
  logic r_valid;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (r_state == IDLE),
    .i_req0  (req0),
    .i_req1  (req1),
    .o_gnt0  (w_gnt0),
    .o_gnt1  (w_gnt1),
    .o_last  (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_div_nxt   = '0;
    w_bit_nxt   = r_bit;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_div_last  = (r_div == DIV_LAST);

    unique case (r_state)
      IDLE: begin
        if (w_gnt0 || w_gnt1) begin
          w_shift_nxt = w_gnt0 ? data0 : data1;
          w_valid_nxt = 1'b0;
          w_state_nxt = CLEAR;
        end
      end

      CLEAR: begin
        if (w_div_last) begin
          w_state_nxt = SHIFT_LO;
          w_bit_nxt   = '0;
          w_data_nxt  = r_shift[0];
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      SHIFT_LO: begin
        if (w_div_last) begin
          w_state_nxt = SHIFT_HI;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      SHIFT_HI: begin
        if (w_div_last) begin
          w_shift_nxt = r_shift >> 1;
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = DONE;
            w_valid_nxt = 1'b1;
          end else begin
            // Next bit is presented together with the falling sclk edge,
            // so data never moves while sclk is high. After the last bit
            // data is simply held.
            w_state_nxt = SHIFT_LO;
            w_data_nxt  = w_shift_nxt[0];
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Pin outputs are decoded from the next state and registered, so they
  // come straight from flops and line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_clr   <= 1'b0;
      r_sclk  <= 1'b0;
      r_data  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_clr   <= (w_state_nxt == CLEAR);
      r_sclk  <= (w_state_nxt == SHIFT_HI);
      r_data  <= w_data_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
      r_valid <= w_valid_nxt;
    end
  end

  assign ack0       = w_gnt0;
  assign ack1       = w_gnt1;
  assign grant_src  = w_last;
  assign unix_clr   = r_clr;
  assign unix_sclk  = r_sclk;
  assign unix_data  = r_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign unix_valid = r_valid;

endmodule

// File: tb/tb_unix_load_sequencer.sv
module tb_unix_load_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] data0 = '0, data1 = '0;
  logic        ack0, ack1, unix_clr, unix_sclk, unix_data;
  logic        busy, done, unix_valid, grant_src;

  logic        b_req0 = 1'b0, b_req1 = 1'b0;
  logic [31:0] b_data0 = '0, b_data1 = '0;
  logic        b_ack0, b_ack1, b_unix_clr, b_unix_sclk, b_unix_data;
  logic        b_busy, b_done, b_unix_valid, b_grant_src;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];

  // Downstream register models: clear on unix_clr, shift in at MSB on
  // every rising sclk so the first bit ends up in bit 0.
  logic [31:0] m_word = '0;
  int          m_cnt = 0;
  logic        m_first = 1'b0;
  logic [31:0] b_m_word = '0;
  int          b_m_cnt = 0;

  always #5 clk = ~clk;

  unix_load_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .unix_clr(unix_clr), .unix_sclk(unix_sclk), .unix_data(unix_data),
    .busy(busy), .done(done), .unix_valid(unix_valid), .grant_src(grant_src)
  );

  unix_load_sequencer #(.WIDTH(32), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req0(b_req0), .data0(b_data0), .ack0(b_ack0),
    .req1(b_req1), .data1(b_data1), .ack1(b_ack1),
    .unix_clr(b_unix_clr), .unix_sclk(b_unix_sclk), .unix_data(b_unix_data),
    .busy(b_busy), .done(b_done), .unix_valid(b_unix_valid), .grant_src(b_grant_src)
  );

  always @(posedge unix_sclk or posedge unix_clr) begin
    if (unix_clr) begin
      m_word = '0;
      m_cnt  = 0;
    end else begin
      if (m_cnt == 0) m_first = unix_data;
      m_word = {unix_data, m_word[31:1]};
      m_cnt++;
    end
  end

  always @(posedge b_unix_sclk or posedge b_unix_clr) begin
    if (b_unix_clr) begin
      b_m_word = '0;
      b_m_cnt  = 0;
    end else begin
      b_m_word = {b_unix_data, b_m_word[31:1]};
      b_m_cnt++;
    end
  end

  // Called on the ack negedge; steps negedges until done (bounded).
  // Optionally withdraws requests and scrambles their data once the
  // word has been captured.
  task automatic wait_done(input bit drop0, input bit drop1,
                           output int cyc, output int clr_cyc);
    cyc = 0;
    clr_cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (drop0) begin req0 = 1'b0; data0 = $urandom; end
        if (drop1) begin req1 = 1'b0; data1 = $urandom; end
      end
      if (unix_clr) clr_cyc++;
    end while (!done && cyc < 2000);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({ack0, ack1, unix_clr, unix_sclk, unix_data, busy, done, unix_valid} !== 8'h00)
      $display("FAIL reset_outputs: got %b expected 00000000",
               {ack0, ack1, unix_clr, unix_sclk, unix_data, busy, done, unix_valid});
    else n_pass++;
    n_total++;
    if (grant_src !== 1'b1) $display("FAIL reset_grant_src: got %b expected 1", grant_src);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({b_ack0, b_ack1, b_unix_clr, b_unix_sclk, b_unix_data, b_busy, b_done, b_unix_valid, b_grant_src} !== 9'b000000001)
      $display("FAIL reset_div1_outputs: got %b expected 000000001",
               {b_ack0, b_ack1, b_unix_clr, b_unix_sclk, b_unix_data, b_busy, b_done, b_unix_valid, b_grant_src});
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_single_load();
    int cyc, clr_cyc;
    logic [31:0] expw;
    @(negedge clk);
    data0 = 32'h5E0BE100;
    req0  = 1'b1;
    #1;
    n_total++;
    if ({ack0, ack1} !== 2'b10) $display("FAIL single_ack: got %b expected 10", {ack0, ack1});
    else n_pass++;
    exp_q.push_back(32'h5E0BE100);
    wait_done(1'b1, 1'b0, cyc, clr_cyc);
    expw = exp_q.pop_front();
    n_total++;
    if (cyc !== 261) $display("FAIL single_latency: got %0d expected 261", cyc);
    else n_pass++;
    n_total++;
    if (clr_cyc !== 4) $display("FAIL single_clr_cycles: got %0d expected 4", clr_cyc);
    else n_pass++;
    n_total++;
    if (m_cnt !== 32) $display("FAIL single_sclk_edges: got %0d expected 32", m_cnt);
    else n_pass++;
    n_total++;
    if (m_word !== expw) $display("FAIL single_word: got %h expected %h", m_word, expw);
    else n_pass++;
    n_total++;
    if (unix_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", unix_valid);
    else n_pass++;
    n_total++;
    if (grant_src !== 1'b0) $display("FAIL single_grant_src: got %b expected 0", grant_src);
    else n_pass++;
  endtask

  task automatic test_lsb_first();
    int cyc, clr_cyc;
    logic [31:0] expw;
    @(negedge clk);
    data1 = 32'h00000001;
    req1  = 1'b1;
    #1;
    n_total++;
    if ({ack0, ack1} !== 2'b01) $display("FAIL lsb_ack: got %b expected 01", {ack0, ack1});
    else n_pass++;
    exp_q.push_back(32'h00000001);
    wait_done(1'b0, 1'b1, cyc, clr_cyc);
    expw = exp_q.pop_front();
    n_total++;
    if (m_first !== 1'b1) $display("FAIL lsb_first_bit: got %b expected 1", m_first);
    else n_pass++;
    n_total++;
    if (m_word !== expw) $display("FAIL lsb_word: got %h expected %h", m_word, expw);
    else n_pass++;
    n_total++;
    if (grant_src !== 1'b1) $display("FAIL lsb_grant_src: got %b expected 1", grant_src);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int cyc, clr_cyc, wt;
    logic [31:0] expw;
    logic [1:0]  exp_ack;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    data0 = 32'hAAAA0000;
    data1 = 32'hBBBB1111;
    req0  = 1'b1;
    req1  = 1'b1;
    #1;
    n_total++;
    if ({ack0, ack1} !== 2'b10) $display("FAIL tie_first_ack: got %b expected 10", {ack0, ack1});
    else n_pass++;
    exp_q.push_back(32'hAAAA0000);
    wait_done(1'b1, 1'b0, cyc, clr_cyc);
    expw = exp_q.pop_front();
    n_total++;
    if (m_word !== expw) $display("FAIL tie_first_word: got %h expected %h", m_word, expw);
    else n_pass++;
    n_total++;
    if (grant_src !== 1'b0) $display("FAIL tie_grant_src: got %b expected 0", grant_src);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({ack0, ack1} !== 2'b01) $display("FAIL tie_second_ack: got %b expected 01", {ack0, ack1});
    else n_pass++;
    exp_q.push_back(32'hBBBB1111);
    wait_done(1'b0, 1'b1, cyc, clr_cyc);
    expw = exp_q.pop_front();
    n_total++;
    if (m_word !== expw) $display("FAIL tie_second_word: got %h expected %h", m_word, expw);
    else n_pass++;

    @(negedge clk);
    data0 = 32'h0C0C0C0C;
    data1 = 32'hD1D1D1D1;
    req0  = 1'b1;
    req1  = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      wt = 0;
      while (!(ack0 || ack1) && wt < 400) begin
        @(negedge clk);
        #1;
        wt++;
      end
      exp_ack = (k % 2 == 0) ? 2'b10 : 2'b01;
      n_total++;
      if ({ack0, ack1} !== exp_ack)
        $display("FAIL rr_alternate_ack%0d: got %b expected %b", k, {ack0, ack1}, exp_ack);
      else n_pass++;
      exp_q.push_back((k % 2 == 0) ? 32'h0C0C0C0C : 32'hD1D1D1D1);
      wait_done(1'b0, 1'b0, cyc, clr_cyc);
      expw = exp_q.pop_front();
      n_total++;
      if (m_word !== expw) $display("FAIL rr_alternate_word%0d: got %h expected %h", k, m_word, expw);
      else n_pass++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_busy();
    int cyc, clr_cyc, early;
    logic [31:0] expw;
    @(negedge clk);
    data0 = 32'h13572468;
    req0  = 1'b1;
    #1;
    n_total++;
    if (ack0 !== 1'b1) $display("FAIL busy_first_ack: got %b expected 1", ack0);
    else n_pass++;
    exp_q.push_back(32'h13572468);
    @(negedge clk);
    req0 = 1'b0;
    repeat (100) @(negedge clk);
    data0 = 32'h87654321;
    req0  = 1'b1;
    early = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) early++;
    end while (!done && cyc < 2000);
    expw = exp_q.pop_front();
    n_total++;
    if (early !== 0) $display("FAIL busy_no_ack: got %0d acks expected 0", early);
    else n_pass++;
    n_total++;
    if (m_word !== expw) $display("FAIL busy_word_unaffected: got %h expected %h", m_word, expw);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (ack0 !== 1'b1) $display("FAIL busy_pending_ack: got %b expected 1", ack0);
    else n_pass++;
    exp_q.push_back(32'h87654321);
    wait_done(1'b1, 1'b0, cyc, clr_cyc);
    expw = exp_q.pop_front();
    n_total++;
    if (m_word !== expw) $display("FAIL busy_pending_word: got %h expected %h", m_word, expw);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc, clr_cyc, wt;
    logic [31:0] expw;
    @(negedge clk);
    data0 = 32'h12345678;
    req0  = 1'b1;
    #1;
    exp_q.push_back(32'h12345678);
    @(negedge clk);
    req0 = 1'b0;
    wt = 0;
    while (m_cnt < 10 && wt < 500) begin
      @(negedge clk);
      wt++;
    end
    n_total++;
    if (m_cnt !== 10) $display("FAIL midreset_reach_bit10: got %0d bits expected 10", m_cnt);
    else n_pass++;
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({ack0, ack1, unix_clr, unix_sclk, unix_data, busy, done, unix_valid} !== 8'h00)
      $display("FAIL midreset_outputs: got %b expected 00000000",
               {ack0, ack1, unix_clr, unix_sclk, unix_data, busy, done, unix_valid});
    else n_pass++;
    n_total++;
    if (grant_src !== 1'b1) $display("FAIL midreset_grant_src: got %b expected 1", grant_src);
    else n_pass++;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    data0 = 32'hFFFFFFFF;
    req0  = 1'b1;
    #1;
    n_total++;
    if (ack0 !== 1'b1) $display("FAIL midreset_reload_ack: got %b expected 1", ack0);
    else n_pass++;
    exp_q.push_back(32'hFFFFFFFF);
    wait_done(1'b1, 1'b0, cyc, clr_cyc);
    expw = exp_q.pop_front();
    n_total++;
    if (cyc !== 261) $display("FAIL midreset_reload_latency: got %0d expected 261", cyc);
    else n_pass++;
    n_total++;
    if (m_word !== expw) $display("FAIL midreset_reload_word: got %h expected %h", m_word, expw);
    else n_pass++;
    n_total++;
    if (unix_valid !== 1'b1) $display("FAIL midreset_reload_valid: got %b expected 1", unix_valid);
    else n_pass++;
  endtask

  task automatic test_clkdiv1();
    int cyc, viol;
    logic prev;
    logic [31:0] expw;
    @(negedge clk);
    b_data0 = 32'hA5A5A5A5;
    b_req0  = 1'b1;
    #1;
    n_total++;
    if (b_ack0 !== 1'b1) $display("FAIL div1_ack: got %b expected 1", b_ack0);
    else n_pass++;
    exp_q.push_back(32'hA5A5A5A5);
    prev = b_unix_data;
    viol = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        b_req0 = 1'b0;
        b_data0 = 32'h0;
      end
      if (b_unix_sclk && (b_unix_data !== prev)) viol++;
      prev = b_unix_data;
    end while (!b_done && cyc < 500);
    expw = exp_q.pop_front();
    n_total++;
    if (cyc !== 66) $display("FAIL div1_latency: got %0d expected 66", cyc);
    else n_pass++;
    n_total++;
    if (b_m_cnt !== 32) $display("FAIL div1_sclk_edges: got %0d expected 32", b_m_cnt);
    else n_pass++;
    n_total++;
    if (b_m_word !== expw) $display("FAIL div1_word: got %h expected %h", b_m_word, expw);
    else n_pass++;
    n_total++;
    if (viol !== 0) $display("FAIL div1_data_stable: got %0d changes expected 0", viol);
    else n_pass++;
    n_total++;
    if (b_unix_valid !== 1'b1) $display("FAIL div1_valid: got %b expected 1", b_unix_valid);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_load();
    test_lsb_first();
    test_simultaneous();
    test_busy();
    test_reset_mid();
    test_clkdiv1();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
